mf_coeff_store: RTL and testbench
=================================

// Module: mf_coeff_store
// PURPOSE
// - Downstream of the MIF coefficient reader: requests the matched-filter impulse-response stream,
//   captures LENGTH complex coefficients (Re/Im) into local buffers, then serves them by address
//   to the FIR datapath.
// - The upstream reader has no valid strobe; capture is aligned by a fixed start latency and is
//   cross-checked against the reader's completion flag.
// PARAMETERS
// - LENGTH        10000  number of complex coefficients captured
// - DATA_WIDTH    16     signed width of each Re/Im coefficient
// - ADDR_WIDTH    14     read/write address width, must satisfy 2**ADDR_WIDTH >= LENGTH
// - START_LATENCY 2      clocks from loadEnable first sampled high by reader to coeff[0] at coeffRe/Im
// - FLAG_TIMEOUT  16     clocks allowed after last capture for coeffSetFlag before ERROR
// PORTS
// - clock        in   1           system clock; all logic on posedge
// - reset        in   1           synchronous, active-low reset
// - start        in   1           pulse/level: begin a load (sampled in IDLE only)
// - loadEnable   out  1           enable to the coefficient reader
// - coeffRe      in   DATA_WIDTH  reader real output (signed)
// - coeffIm      in   DATA_WIDTH  reader imag output (signed)
// - coeffSetFlag in   1           reader completion flag
// - readEnable   in   1           read request from FIR (honoured in READY only)
// - readAddr     in   ADDR_WIDTH  coefficient index 0..LENGTH-1
// - readRe       out  DATA_WIDTH  registered real coefficient
// - readIm       out  DATA_WIDTH  registered imag coefficient
// - readValid    out  1           readRe/readIm valid this cycle
// - coeffReady   out  1           buffers fully loaded and verified
// - loadError    out  1           load failed (early/missing flag); sticky until reset
// BEHAVIOUR
// - Reset (reset==0 at posedge): state IDLE; all outputs 0; counters 0. Buffer contents undefined.
// - IDLE: start==1 -> loadEnable<=1, latency counter<=0, go REQUEST.
// - REQUEST: loadEnable held 1; after START_LATENCY clocks go CAPTURE. Timing contract: reader
//   samples loadEnable at edge E0, drives coeff[k] at edge E1+k, coeffSetFlag at E1+LENGTH.
// - CAPTURE: each clock write {coeffRe,coeffIm} to buffer[writeCount], writeCount++; captures at
//   edges E2..E1+LENGTH. loadEnable<=0 on entry. After writing index LENGTH-1 go WAIT_FLAG.
//   coeffSetFlag==1 while writeCount<LENGTH-1 -> ERROR (early flag).
// - WAIT_FLAG: coeffSetFlag==1 -> coeffReady<=1, go READY (nominally 1 clock after last capture).
//   No flag within FLAG_TIMEOUT clocks -> ERROR.
// - READY: coeffReady=1. readEnable==1 -> next clock readRe/readIm=buffer[readAddr], readValid=1
//   (latency 1, one read per clock, back-to-back allowed). readAddr>=LENGTH -> data 0, readValid=1.
//   readEnable==0 -> readValid<=0, readRe/readIm hold. start ignored (reader is one-shot).
// - ERROR: loadError=1, coeffReady=0, loadEnable=0, reads ignored (readValid=0); exit only by reset.
// - Reads in any state other than READY: readValid=0, data unchanged.
// - Reset mid-load: return to IDLE immediately; coeffReady/loadError cleared; partial data discarded.
// - Simultaneous start and readEnable in IDLE: start wins; no read issued.
// - Undefined state encoding: go IDLE, outputs cleared.
// - No arithmetic on data; values stored/returned bit-exact, signed, DATA_WIDTH wide.
// STRUCTURE
// - Shared package: state encoding localparams (IDLE, REQUEST, CAPTURE, WAIT_FLAG, READY, ERROR),
//   DATA_WIDTH/ADDR_WIDTH/LENGTH defaults shared with reader and FIR.
// - One sub-module: mf_coeff_ram (simple dual-port, 1 write/1 registered read, 2*DATA_WIDTH wide,
//   LENGTH deep) so it infers block RAM; FSM and counters stay in top.
// TESTING (LENGTH=8, DATA_WIDTH=16, bench model reproduces reader timing)
// - Normal load: start pulse, coeff[k]=(k+1, -(k+1)) -> loadEnable high 2 clocks, coeffReady=1
//   exactly 1 clock after last capture (E1+LENGTH+1); loadError=0.
// - Readback: read addr 0..7 back-to-back -> readValid each next clock, readRe=k+1, readIm=-(k+1).
// - Out of range/not ready: readAddr=9 in READY -> readRe=readIm=0, readValid=1; read before
//   READY -> readValid=0.
// - Early flag: assert coeffSetFlag at 4th capture -> loadError=1, coeffReady=0, stays until reset.
// - Missing flag: never assert coeffSetFlag -> loadError=1 FLAG_TIMEOUT (16) clocks after last capture.
// - Reset mid-CAPTURE (after 3 samples) -> next clock IDLE, all outputs 0; new start reloads cleanly.

Source files
------------

// File: rtl/mf_coeff_store_pkg.sv
// mf_coeff_store_pkg: shared sizes and state encoding for the matched-filter coefficient path.
package mf_coeff_store_pkg;
  localparam int MF_LENGTH        = 10000;
  localparam int MF_DATA_WIDTH    = 16;
  localparam int MF_ADDR_WIDTH    = 14;
  localparam int MF_START_LATENCY = 2;
  localparam int MF_FLAG_TIMEOUT  = 16;
  typedef enum logic [2:0] {IDLE, REQUEST, CAPTURE, WAIT_FLAG, READY, ERROR} state_t;
endpackage

// File: rtl/mf_coeff_ram.sv
// mf_coeff_ram: simple dual-port RAM, one write and one registered read port.
module mf_coeff_ram #(
  parameter int DEPTH = 10000,
  parameter int WIDTH = 32,
  parameter int AW    = 14
)(
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic unused_hi;
  assign unused_hi = ^{waddr, raddr};
  always_ff @(posedge clock) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[IW-1:0]];
  end
endmodule

// File: rtl/mf_coeff_store.sv
// mf_coeff_store: captures the reader's coefficient stream by fixed latency, verifies the
// completion flag, then serves coefficients by address with one clock of read latency.
module mf_coeff_store
  import mf_coeff_store_pkg::*;
#(
  parameter int LENGTH        = MF_LENGTH,
  parameter int DATA_WIDTH    = MF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = MF_ADDR_WIDTH,
  parameter int START_LATENCY = MF_START_LATENCY,
  parameter int FLAG_TIMEOUT  = MF_FLAG_TIMEOUT
)(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         loadEnable,
  input  logic signed [DATA_WIDTH-1:0] coeffRe,
  input  logic signed [DATA_WIDTH-1:0] coeffIm,
  input  logic                         coeffSetFlag,
  input  logic                         readEnable,
  input  logic [ADDR_WIDTH-1:0]        readAddr,
  output logic signed [DATA_WIDTH-1:0] readRe,
  output logic signed [DATA_WIDTH-1:0] readIm,
  output logic                         readValid,
  output logic                         coeffReady,
  output logic                         loadError
);
  localparam int CW = $clog2(START_LATENCY + FLAG_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [CW-1:0] LAT_END = CW'(START_LATENCY - 1);
  localparam logic [CW-1:0] TO_END  = CW'(FLAG_TIMEOUT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] wr_cnt, wr_cnt_n;
  logic we, rd, zero;
  logic [2*DATA_WIDTH-1:0] rd_data;
  assign loadEnable = state == REQUEST;
  assign coeffReady = state == READY;
  assign loadError  = state == ERROR;
  assign rd         = coeffReady && readEnable;
  // Out-of-range reads and the post-reset state both present zero without touching the RAM.
  assign readRe = zero ? '0 : rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign readIm = zero ? '0 : rd_data[DATA_WIDTH-1:0];
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wr_cnt_n = wr_cnt;
    we       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = REQUEST;
        cnt_n   = '0;
      end
      REQUEST: if (cnt == LAT_END) begin
        state_n  = CAPTURE;
        wr_cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
      CAPTURE: begin
        we       = 1'b1;
        wr_cnt_n = wr_cnt + 1'b1;
        if (coeffSetFlag && wr_cnt != LAST) state_n = ERROR;
        else if (wr_cnt == LAST) begin
          state_n = WAIT_FLAG;
          cnt_n   = '0;
        end
      end
      WAIT_FLAG: if (coeffSetFlag) state_n = READY;
        else if (cnt == TO_END) state_n = ERROR;
        else cnt_n = cnt + 1'b1;
      READY, ERROR: state_n = state;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_cnt    <= '0;
      readValid <= 1'b0;
      zero      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wr_cnt    <= wr_cnt_n;
      readValid <= rd;
      if (rd) zero <= readAddr > LAST;
    end
  end
  mf_coeff_ram #(.DEPTH(LENGTH), .WIDTH(2*DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_cnt),
    .wdata ({coeffRe, coeffIm}),
    .re    (rd && readAddr <= LAST),
    .raddr (readAddr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_mf_coeff_store.sv
// tb_mf_coeff_store: directed bench with a reader timing model and a read-data scoreboard.
module tb_mf_coeff_store;
  localparam int L = 8;
  logic clock, reset, start, loadEnable, coeffSetFlag, readEnable;
  logic signed [15:0] coeffRe, coeffIm, readRe, readIm;
  logic [13:0] readAddr;
  logic readValid, coeffReady, loadError;
  int tests, fails, flag_mode, base, le_cnt, idx, phase, k;
  bit pend;
  typedef struct {int re; int im;} exp_t;
  exp_t sb[$];
  mf_coeff_store #(.LENGTH(L), .DATA_WIDTH(16), .ADDR_WIDTH(14)) dut (
    .clock(clock), .reset(reset), .start(start), .loadEnable(loadEnable),
    .coeffRe(coeffRe), .coeffIm(coeffIm), .coeffSetFlag(coeffSetFlag),
    .readEnable(readEnable), .readAddr(readAddr), .readRe(readRe), .readIm(readIm),
    .readValid(readValid), .coeffReady(coeffReady), .loadError(loadError)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  // Reader model: samples loadEnable at E0, drives coeff[k] at E1+k, flag at E1+L.
  always @(posedge clock) begin
    if (!reset) begin
      phase <= 0; k <= 0; coeffRe <= '0; coeffIm <= '0; coeffSetFlag <= 1'b0;
    end else if (phase == 0) begin
      if (loadEnable) begin phase <= 1; k <= 0; end
    end else if (phase == 1) begin
      coeffRe <= 16'(base + k + 1);
      coeffIm <= 16'(-(base + k + 1));
      if (flag_mode == 1 && k == 3) coeffSetFlag <= 1'b1;
      k <= k + 1;
      if (k == L - 1) phase <= 2;
    end else if (phase == 2) begin
      if (flag_mode != 2) coeffSetFlag <= 1'b1;
      phase <= 3;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    exp_t e;
    @(negedge clock);
    chk("read_valid", 32'(readValid), 32'(pend));
    if (pend && sb.size() > 0) begin
      e = sb.pop_front();
      chk("read_re", 32'(readRe), e.re);
      chk("read_im", 32'(readIm), e.im);
    end
    pend = 1'b0;
  endtask
  task automatic rd(input int a, input bit v, input int re, input int im);
    readEnable = 1'b1;
    readAddr = 14'(a);
    if (v) sb.push_back('{re, im});
    pend = v;
    cyc();
    readEnable = 1'b0;
  endtask
  task automatic load(input bit want_err, input int stop_at, output int at);
    le_cnt = 0;
    at = -1;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      start = 1'b0;
      readEnable = 1'b0;
      if (i == 0) chk("start_wins_no_read", 32'(readValid), 0);
      le_cnt += int'(loadEnable);
      if (i == stop_at || (want_err ? loadError : coeffReady)) begin
        at = i;
        break;
      end
    end
  endtask
  task automatic outs_zero(input string tag);
    chk({tag, "_le"}, 32'(loadEnable), 0);
    chk({tag, "_ready"}, 32'(coeffReady), 0);
    chk({tag, "_err"}, 32'(loadError), 0);
    chk({tag, "_rv"}, 32'(readValid), 0);
    chk({tag, "_re"}, 32'(readRe), 0);
    chk({tag, "_im"}, 32'(readIm), 0);
  endtask
  initial begin
    tests = 0; fails = 0; flag_mode = 0; base = 0; pend = 1'b0;
    reset = 1'b0; start = 1'b0; readEnable = 1'b0; readAddr = '0;
    repeat (2) @(negedge clock);
    outs_zero("reset");
    reset = 1'b1;
    rd(0, 1'b0, 0, 0);
    chk("idle_read_data", 32'(readRe), 0);
    // Normal load with a simultaneous read request in IDLE.
    readEnable = 1'b1;
    load(1'b0, -1, idx);
    chk("ready_latency", idx, 11);
    chk("load_enable_clocks", le_cnt, 2);
    chk("normal_no_error", 32'(loadError), 0);
    for (int a = 0; a < L; a++) rd(a, 1'b1, a + 1, -(a + 1));
    cyc();
    chk("hold_re", 32'(readRe), 8);
    chk("hold_im", 32'(readIm), -8);
    rd(9, 1'b1, 0, 0);
    cyc();
    chk("oor_hold_re", 32'(readRe), 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ignored_ready", 32'(coeffReady), 1);
    chk("start_ignored_le", 32'(loadEnable), 0);
    rd(3, 1'b1, 4, -4);
    // Early completion flag.
    reset = 1'b0; cyc(); reset = 1'b1;
    flag_mode = 1;
    load(1'b1, -1, idx);
    chk("early_err_at", idx, 6);
    chk("early_not_ready", 32'(coeffReady), 0);
    repeat (20) cyc();
    chk("early_err_sticky", 32'(loadError), 1);
    rd(0, 1'b0, 0, 0);
    chk("early_le_low", 32'(loadEnable), 0);
    // Missing completion flag.
    reset = 1'b0; cyc(); reset = 1'b1;
    flag_mode = 2;
    load(1'b1, -1, idx);
    chk("timeout_err_at", idx, 26);
    chk("timeout_not_ready", 32'(coeffReady), 0);
    // Reset after three captures, then reload with different data.
    reset = 1'b0; cyc(); reset = 1'b1;
    flag_mode = 0;
    load(1'b0, 5, idx);
    chk("mid_stop_at", idx, 5);
    reset = 1'b0;
    cyc();
    outs_zero("mid_reset");
    reset = 1'b1;
    base = 100;
    load(1'b0, -1, idx);
    chk("reload_latency", idx, 11);
    chk("reload_no_error", 32'(loadError), 0);
    for (int a = L - 1; a >= 0; a--) rd(a, 1'b1, base + a + 1, -(base + a + 1));
    cyc();
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
